// File: rtl/tt_sel_driver.sv
`timescale 1ns/1ps
// tt_sel_driver: host-side sequencer for the chip project-select pins
// (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena); all pin outputs are registered.
//
// Sequence per request: disable (OFF), counter reset (RST), reset gap (RGAP),
// N increment pulses (INC_HI/INC_LO), then FIN applies the requested ena.
//
// Optional macro TT_SELDRV_INCR_EN: when the chip counter value is known and
// the target is at or above it, skip the reset and pulse only the difference.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_addr, req_ena   target address and ena level to apply
//   done                one-cycle pulse at sequence completion
//   cur_addr, cur_valid address held by the chip counter and its validity
//   sel_rst_n, sel_inc, ena  pad drivers
module tt_sel_driver #(
    parameter int ADDR_W  = 10,
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 4,
    parameter int RST_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              sel_rst_n,
    output logic              sel_inc,
    output logic              ena
);

    localparam int MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAX_W  = (MAX_PG > RST_W) ? MAX_PG : RST_W;
    localparam int TW     = $clog2(MAX_W) + 1;

    // Timer reload values: a phase of W cycles loads W-1 and ends at zero.
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_W - 1);
    localparam logic [TW-1:0] T_RST   = TW'(RST_W - 1);

    typedef enum logic [2:0] {
        S_PRST,
        S_IDLE,
        S_OFF,
        S_RST,
        S_RGAP,
        S_INC_HI,
        S_INC_LO,
        S_FIN
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] inc_cnt;
    logic              tgt_ena;
`ifdef TT_SELDRV_INCR_EN
    logic              skip_rst;
`endif

    logic timer_done;
    logic more_inc;

    assign timer_done = (timer == '0);
    assign more_inc   = (inc_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PRST;
            timer     <= T_RST;
            inc_cnt   <= '0;
            tgt_ena   <= 1'b0;
`ifdef TT_SELDRV_INCR_EN
            skip_rst  <= 1'b0;
`endif
            req_ready <= 1'b0;
            done      <= 1'b0;
            cur_addr  <= '0;
            cur_valid <= 1'b0;
            sel_rst_n <= 1'b0;
            sel_inc   <= 1'b0;
            ena       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!timer_done) begin
                timer <= timer - 1'b1;
            end

            unique case (state)
                S_PRST: begin
                    if (timer_done) begin
                        sel_rst_n <= 1'b1;
                        cur_addr  <= '0;
                        cur_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    // req_ready is only ever high in IDLE.
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        tgt_ena   <= req_ena;
                        ena       <= 1'b0;
                        timer     <= T_GAP;
                        state     <= S_OFF;
`ifdef TT_SELDRV_INCR_EN
                        if (cur_valid && (req_addr >= cur_addr)) begin
                            inc_cnt  <= req_addr - cur_addr;
                            skip_rst <= 1'b1;
                        end else begin
                            inc_cnt  <= req_addr;
                            skip_rst <= 1'b0;
                        end
`else
                        inc_cnt <= req_addr;
`endif
                    end
                end

                S_OFF: begin
                    if (timer_done) begin
`ifdef TT_SELDRV_INCR_EN
                        if (skip_rst) begin
                            if (more_inc) begin
                                sel_inc <= 1'b1;
                                timer   <= T_PULSE;
                                state   <= S_INC_HI;
                            end else begin
                                state <= S_FIN;
                            end
                        end else begin
                            sel_rst_n <= 1'b0;
                            cur_valid <= 1'b0;
                            cur_addr  <= '0;
                            timer     <= T_RST;
                            state     <= S_RST;
                        end
`else
                        sel_rst_n <= 1'b0;
                        cur_valid <= 1'b0;
                        cur_addr  <= '0;
                        timer     <= T_RST;
                        state     <= S_RST;
`endif
                    end
                end

                S_RST: begin
                    if (timer_done) begin
                        sel_rst_n <= 1'b1;
                        timer     <= T_GAP;
                        state     <= S_RGAP;
                    end
                end

                S_RGAP: begin
                    if (timer_done) begin
                        if (more_inc) begin
                            sel_inc <= 1'b1;
                            timer   <= T_PULSE;
                            state   <= S_INC_HI;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end

                S_INC_HI: begin
                    // The chip counter advances on the falling edge of sel_inc.
                    if (timer_done) begin
                        sel_inc  <= 1'b0;
                        cur_addr <= cur_addr + 1'b1;
                        inc_cnt  <= inc_cnt - 1'b1;
                        timer    <= T_GAP;
                        state    <= S_INC_LO;
                    end
                end

                S_INC_LO: begin
                    if (timer_done) begin
                        if (more_inc) begin
                            sel_inc <= 1'b1;
                            timer   <= T_PULSE;
                            state   <= S_INC_HI;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end

                S_FIN: begin
                    ena       <= tgt_ena;
                    done      <= 1'b1;
                    cur_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_PRST;
                end
            endcase
        end
    end

    // Pad-level safety: never pulse the counter while it is held in reset.
    a_inc_vs_rst: assert property (
        @(posedge clk) disable iff (!rst_n) !(sel_inc && !sel_rst_n)
    );

    a_rst_invalid: assert property (
        @(posedge clk) disable iff (!rst_n) !sel_rst_n |-> !cur_valid
    );

endmodule

// File: tb/tb_tt_sel_driver.sv
`timescale 1ns/1ps
// Bench for tt_sel_driver: reset, request table with scoreboard,
// async reset mid-increment, and request-while-busy.
module tb_tt_sel_driver;

    localparam int AW = 10;
    localparam int PW = 2;
    localparam int GW = 2;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ena = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          done;
    logic [AW-1:0] cur_addr;
    logic          cur_valid;
    logic          sel_rst_n;
    logic          sel_inc;
    logic          ena;

    tt_sel_driver #(
        .ADDR_W (AW),
        .PULSE_W(PW),
        .GAP_W  (GW),
        .RST_W  (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_ena  (req_ena),
        .done     (done),
        .cur_addr (cur_addr),
        .cur_valid(cur_valid),
        .sel_rst_n(sel_rst_n),
        .sel_inc  (sel_inc),
        .ena      (ena)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int   pulses = 0;
    int   rst_lows = 0;
    int   inv_err = 0;
    logic prev_inc = 1'b0;

    // Pin monitor: counts pulses / reset-low cycles and pin invariants.
    always @(negedge clk) begin
        if (sel_inc && !prev_inc) pulses++;
        prev_inc = sel_inc;
        if (!sel_rst_n) rst_lows++;
        if (sel_inc && !sel_rst_n) inv_err++;
        if (!sel_rst_n && cur_valid) inv_err++;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic          ena;
        int            lat;
        int            np;
        int            nr;
    } vec_t;

    typedef struct {
        int            lat;
        int            np;
        int            nr;
        logic [AW-1:0] addr;
        logic          ena;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("ready_before_req", int'(req_ready), 1);
    endtask

    task automatic do_req(input logic [AW-1:0] a, input logic e,
                          input int lat, input int np, input int nr);
        exp_t x;
        int   cyc;
        wait_ready();
        req_addr  = a;
        req_ena   = e;
        req_valid = 1'b1;
        x = '{lat: lat, np: np, nr: nr, addr: a, ena: e};
        sb.push_back(x);
        @(posedge clk);
        #1;
        pulses    = 0;
        rst_lows  = 0;
        req_valid = 1'b0;
        chk("ready_drop", int'(req_ready), 0);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", int'(done), 1);
        if (done && sb.size() > 0) begin
            x = sb.pop_front();
            chk("latency", cyc, x.lat);
            chk("pulses", pulses, x.np);
            chk("rst_low_cycles", rst_lows, x.nr);
            chk("cur_addr", int'(cur_addr), int'(x.addr));
            chk("ena", int'(ena), int'(x.ena));
            chk("cur_valid", int'(cur_valid), 1);
            chk("ready_after", int'(req_ready), 1);
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic release_reset();
        int c = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!sel_rst_n && c < 20);
        chk("prst_low_cycles", c, RW);
        chk("prst_cur_valid", int'(cur_valid), 1);
        chk("prst_cur_addr", int'(cur_addr), 0);
        chk("prst_ready", int'(req_ready), 1);
        chk("prst_ena", int'(ena), 0);
        chk("prst_sel_inc", int'(sel_inc), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel_rst_n"}, int'(sel_rst_n), 0);
        chk({tag, "_sel_inc"}, int'(sel_inc), 0);
        chk({tag, "_ena"}, int'(ena), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ready"}, int'(req_ready), 0);
        chk({tag, "_cur_addr"}, int'(cur_addr), 0);
        chk({tag, "_cur_valid"}, int'(cur_valid), 0);
    endtask

    initial begin
        int c;
        int ndone;
        int lat6;
        int nr6;

`ifdef TT_SELDRV_INCR_EN
        vecs[0] = '{addr: 10'd5,  ena: 1'b1, lat: 23, np: 5, nr: 0};
        vecs[1] = '{addr: 10'd0,  ena: 1'b1, lat: 9,  np: 0, nr: 4};
        vecs[2] = '{addr: 10'd5,  ena: 1'b0, lat: 23, np: 5, nr: 0};
        vecs[3] = '{addr: 10'd7,  ena: 1'b1, lat: 11, np: 2, nr: 0};
        vecs[4] = '{addr: 10'd3,  ena: 1'b0, lat: 21, np: 3, nr: 4};
        vecs[5] = '{addr: 10'd3,  ena: 1'b1, lat: 3,  np: 0, nr: 0};
        vecs[6] = '{addr: 10'd12, ena: 1'b1, lat: 39, np: 9, nr: 0};
        lat6 = 11;
        nr6  = 0;
`else
        vecs[0] = '{addr: 10'd5,  ena: 1'b1, lat: 29, np: 5,  nr: 4};
        vecs[1] = '{addr: 10'd0,  ena: 1'b1, lat: 9,  np: 0,  nr: 4};
        vecs[2] = '{addr: 10'd5,  ena: 1'b0, lat: 29, np: 5,  nr: 4};
        vecs[3] = '{addr: 10'd7,  ena: 1'b1, lat: 37, np: 7,  nr: 4};
        vecs[4] = '{addr: 10'd3,  ena: 1'b0, lat: 21, np: 3,  nr: 4};
        vecs[5] = '{addr: 10'd3,  ena: 1'b1, lat: 21, np: 3,  nr: 4};
        vecs[6] = '{addr: 10'd12, ena: 1'b1, lat: 57, np: 12, nr: 4};
        lat6 = 17;
        nr6  = 4;
`endif

        // Power-on reset
        #23;
        chk_reset_vals("rst");
        release_reset();

        // Request table
        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].addr, vecs[i].ena,
                   vecs[i].lat, vecs[i].np, vecs[i].nr);
        end

        // Async reset during the third increment pulse
        wait_ready();
        req_addr  = 10'd5;
        req_ena   = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pulses    = 0;
        c = 0;
        while (pulses < 3 && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("mid_inc_hi", int'(sel_inc), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        #20;
        release_reset();

        // Request while busy is ignored
        req_addr  = 10'd2;
        req_ena   = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        pulses   = 0;
        rst_lows = 0;
        req_addr = 10'd9;
        c = 0;
        while (!done && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        req_valid = 1'b0;
        chk("busy_done_seen", int'(done), 1);
        chk("busy_latency", c, lat6);
        chk("busy_pulses", pulses, 2);
        chk("busy_rst_low", rst_lows, nr6);
        chk("busy_cur_addr", int'(cur_addr), 2);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("busy_extra_done", ndone, 0);
        chk("busy_pulses_after", pulses, 2);
        chk("busy_addr_after", int'(cur_addr), 2);
        chk("busy_ready_after", int'(req_ready), 1);

        chk("pin_invariants", inv_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
